// File: rtl/fwd_sel_unit.sv
// Operand-forwarding select and load-use stall unit for the EX-stage muxes of a 5-stage core.
// Build option: define FWD_SEL_FORWARDING_EN for forwarding; otherwise every RAW hazard stalls.
module fwd_sel_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_reg_write_i,
   input  logic                  id_mem_read_i,
   input  logic                  flush_i,
   output logic [1:0]            sel_a_o,
   output logic [1:0]            sel_b_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   typedef enum logic [1:0] {
      SEL_RF  = 2'b00,
      SEL_MEM = 2'b01,
      SEL_WB  = 2'b10
   } sel_e;

   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q;
   logic                  ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, mem_wr_q;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
   logic                  bubble;
   logic                  a_ex, a_mem, b_ex, b_mem;

   // A source matches a producer only if it is really read and is not x0.
   assign a_ex  = id_use_rs1_i && (id_rs1_i != '0) && ex_wr_q  && (ex_rd_q  == id_rs1_i);
   assign a_mem = id_use_rs1_i && (id_rs1_i != '0) && mem_wr_q && (mem_rd_q == id_rs1_i);
   assign b_ex  = id_use_rs2_i && (id_rs2_i != '0) && ex_wr_q  && (ex_rd_q  == id_rs2_i);
   assign b_mem = id_use_rs2_i && (id_rs2_i != '0) && mem_wr_q && (mem_rd_q == id_rs2_i);

`ifdef FWD_SEL_FORWARDING_EN
   sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;

   assign stall_o = id_valid_i && !flush_i && ex_ld_q && (a_ex || b_ex);

   // The newest producer wins: a result still in EX now will be in MEM next cycle.
   always_comb begin
      sel_a_d = SEL_RF;
      sel_b_d = SEL_RF;
      if (!bubble) begin
         if (a_ex)       sel_a_d = SEL_MEM;
         else if (a_mem) sel_a_d = SEL_WB;
         if (b_ex)       sel_b_d = SEL_MEM;
         else if (b_mem) sel_b_d = SEL_WB;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
      end else begin
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   assign sel_a_o = sel_a_q;
   assign sel_b_o = sel_b_q;
`else
   logic unused_ex_ld;

   assign stall_o      = id_valid_i && !flush_i && (a_ex || a_mem || b_ex || b_mem);
   assign sel_a_o      = SEL_RF;
   assign sel_b_o      = SEL_RF;
   assign unused_ex_ld = ex_ld_q;
`endif

   assign bubble = stall_o || flush_i;

   // NOTE: every variable gets a default first so this block cannot infer a latch.
   always_comb begin
      ex_rd_d     = id_rd_i;
      ex_wr_d     = id_valid_i && id_reg_write_i;
      ex_ld_d     = id_valid_i && id_mem_read_i;
      stall_cnt_d = stall_cnt_q;
      if (bubble) begin
         ex_rd_d = '0;
         ex_wr_d = 1'b0;
         ex_ld_d = 1'b0;
      end
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ex_rd_q     <= '0;
         ex_wr_q     <= 1'b0;
         ex_ld_q     <= 1'b0;
         mem_rd_q    <= '0;
         mem_wr_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         ex_rd_q     <= ex_rd_d;
         ex_wr_q     <= ex_wr_d;
         ex_ld_q     <= ex_ld_d;
         mem_rd_q    <= ex_rd_q;
         mem_wr_q    <= ex_wr_q;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Scoreboard bench for fwd_sel_unit: a history-based reference model predicts STALL, SEL and STALL_CNT.
module tb_fwd_sel_unit;
   localparam int AW      = 5;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FWD_SEL_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic [1:0]    sel_a, sel_b;
   logic          stall;
   logic [CW-1:0] stall_cnt;

   always #5 clk = ~clk;

   fwd_sel_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .id_valid_i     (id_valid),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_use_rs1_i   (id_use_rs1),
      .id_use_rs2_i   (id_use_rs2),
      .id_rd_i        (id_rd),
      .id_reg_write_i (id_reg_write),
      .id_mem_read_i  (id_mem_read),
      .flush_i        (flush),
      .sel_a_o        (sel_a),
      .sel_b_o        (sel_b),
      .stall_o        (stall),
      .stall_cnt_o    (stall_cnt)
   );

   typedef struct {
      bit          v, u1, u2, rw, ld, fl, rst;
      bit [AW-1:0] rs1, rs2, rd;
   } instr_t;

   // One entry per instruction that entered EX, newest first; bubbles are entries that write nothing.
   typedef struct {
      bit          wr, ld;
      bit [AW-1:0] rd;
   } occ_t;

   typedef struct {
      bit       stall;
      bit [1:0] sa, sb;
      int       cnt;
   } exp_t;

   occ_t hist[$];
   exp_t exp_q[$];
   int   exp_cnt = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
   endtask

   // How many instructions ahead the newest writer of rs is (1 or 2), or 0 if none.
   function automatic int producer_dist(input bit used, input bit [AW-1:0] rs);
      if (!used || rs == 0) return 0;
      for (int d = 0; d < hist.size() && d < 2; d++)
         if (hist[d].wr && hist[d].rd == rs) return d + 1;
      return 0;
   endfunction

   task automatic step(input instr_t in, output bit st);
      exp_t e;
      occ_t o;
      int   da, db;
      bit   load_use;
      @(negedge clk);
      rst_n        = !in.rst;
      id_valid     = in.v;
      id_rs1       = in.rs1;
      id_rs2       = in.rs2;
      id_use_rs1   = in.u1;
      id_use_rs2   = in.u2;
      id_rd        = in.rd;
      id_reg_write = in.rw;
      id_mem_read  = in.ld;
      flush        = in.fl;
      da = producer_dist(in.u1, in.rs1);
      db = producer_dist(in.u2, in.rs2);
      if (FWD) begin
         load_use = hist.size() > 0 && hist[0].ld && hist[0].wr && hist[0].rd != 0 &&
                    ((in.u1 && in.rs1 == hist[0].rd) || (in.u2 && in.rs2 == hist[0].rd));
         st   = in.v && !in.fl && load_use;
         e.sa = (st || in.fl) ? 2'd0 : 2'(da);
         e.sb = (st || in.fl) ? 2'd0 : 2'(db);
      end else begin
         st   = in.v && !in.fl && (da != 0 || db != 0);
         e.sa = 2'd0;
         e.sb = 2'd0;
      end
      e.stall = st;
      if (in.rst) begin
         hist.delete();
         exp_cnt = 0;
         e.sa    = 2'd0;
         e.sb    = 2'd0;
      end else begin
         o.wr = !(st || in.fl) && in.v && in.rw;
         o.ld = !(st || in.fl) && in.v && in.ld;
         o.rd = in.rd;
         hist.push_front(o);
         if (hist.size() > 2) void'(hist.pop_back());
         if (st && exp_cnt < CNT_MAX) exp_cnt++;
      end
      e.cnt = exp_cnt;
      exp_q.push_back(e);
   endtask

   // A stalled instruction stays in ID and is presented again until it issues.
   task automatic send(input instr_t in);
      bit st;
      if (in.rst) begin
         step(in, st);
         return;
      end
      for (int k = 0; k < 3; k++) begin
         step(in, st);
         if (!st) return;
      end
   endtask

   function automatic instr_t nop();
      instr_t i = '{default: 0};
      return i;
   endfunction

   function automatic instr_t rst_op();
      instr_t i = '{default: 0};
      i.rst = 1'b1;
      return i;
   endfunction

   function automatic instr_t alu(input int rd, input int rs1, input int rs2);
      instr_t i = '{default: 0};
      i.v = 1'b1; i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
      i.rd = AW'(rd); i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
      return i;
   endfunction

   function automatic instr_t lw(input int rd, input int rs1);
      instr_t i = '{default: 0};
      i.v = 1'b1; i.u1 = 1'b1; i.rw = 1'b1; i.ld = 1'b1;
      i.rd = AW'(rd); i.rs1 = AW'(rs1);
      return i;
   endfunction

   task automatic expect_cnt(input string name, input int exp_v);
      @(posedge clk);
      #1;
      check(name, int'(stall_cnt), exp_v);
   endtask

   // Monitor: STALL is sampled late in the cycle, SEL and STALL_CNT just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall", int'(stall), int'(e.stall));
            @(posedge clk);
            #1;
            check("sel_a", int'(sel_a), int'(e.sa));
            check("sel_b", int'(sel_b), int'(e.sb));
            check("stall_cnt", int'(stall_cnt), e.cnt);
         end
      end
   end

   initial begin
      instr_t r;
      rst_n = 1'b0; id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;

      // add x5 ; add x6,x5,x1
      send(rst_op()); send(alu(5, 1, 2)); send(alu(6, 5, 1)); send(nop());
      expect_cnt("s1_cnt", FWD ? 0 : 2);
      // add x5 ; nop ; add x6,x1,x5
      send(rst_op()); send(alu(5, 1, 2)); send(nop()); send(alu(6, 1, 5)); send(nop());
      expect_cnt("s2_cnt", FWD ? 0 : 1);
      // lw x5 ; add x7,x5,x5
      send(rst_op()); send(lw(5, 1)); send(alu(7, 5, 5)); send(nop());
      expect_cnt("s3_cnt", FWD ? 1 : 2);
      // add x0 ; add x6,x0,x0
      send(rst_op()); send(alu(0, 1, 2)); send(alu(6, 0, 0)); send(nop());
      expect_cnt("s4_cnt", 0);
      // lw x5 ; add x7,x5,x5 flushed in the hazard cycle
      send(rst_op()); send(lw(5, 1));
      r = alu(7, 5, 5); r.fl = 1'b1; send(r); send(nop());
      expect_cnt("s5_cnt", 0);
      // add x5 ; add x6,x5,x3
      send(rst_op()); send(alu(5, 1, 2)); send(alu(6, 5, 3)); send(nop());
      expect_cnt("s6_cnt", FWD ? 0 : 2);
      // reset asserted during a load-use stall cycle
      send(rst_op()); send(lw(5, 1));
      r = alu(7, 5, 5); r.rst = 1'b1; send(r);
      send(alu(7, 5, 5)); send(nop());
      expect_cnt("s7_cnt", 0);
      // counter saturation
      send(rst_op());
      for (int k = 0; k < 20; k++) begin
         send(lw(5, 1));
         send(alu(6, 5, 0));
      end
      send(nop());
      expect_cnt("sat_cnt", CNT_MAX);

      // randomized traffic over a small register set to provoke frequent hazards
      send(rst_op());
      for (int k = 0; k < 600; k++) begin
         r     = '{default: 0};
         r.v   = ($urandom % 10) != 0;
         r.rs1 = AW'($urandom_range(0, 3));
         r.rs2 = AW'($urandom_range(0, 3));
         r.rd  = AW'($urandom_range(0, 3));
         r.u1  = r.v && $urandom_range(0, 1) == 1;
         r.u2  = r.v && $urandom_range(0, 1) == 1;
         r.rw  = $urandom_range(0, 1) == 1;
         r.ld  = r.rw && ($urandom % 3) == 0;
         r.fl  = ($urandom % 8) == 0;
         r.rst = ($urandom % 150) == 0;
         send(r);
      end
      send(nop());

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
